// File: rtl/rf_mp.sv
// rf_mp: multi-ported register file with a post-reset zeroing sweep.
//   After reset the file sweeps every entry to zero, one per cycle
//   (init_busy=1). In READY it accepts WR_N writes and serves RD_N reads
//   per cycle.
//
// Parameters:
//   W         entry width in bits
//   N         entry count (>= 2, need not be a power of two)
//   WR_N      write port count
//   RD_N      read port count
//   FLOP_OUT  1: registered read data, 0: combinational read data
//   BYPASS    1: same-cycle write-to-read forwarding
//
// Ports:
//   clk, rst   clock; asynchronous active-high reset
//   ra, ren    per-port read address; read enable (used only with FLOP_OUT=1)
//   rdata      per-port read data
//   rvalid     per-port flag: addressed entry written since the last sweep
//   wa, wen    per-port write address and write enable
//   wdata      per-port write data
//   init_busy  high while the zeroing sweep runs
module rf_mp #(
  parameter int unsigned W        = 32,
  parameter int unsigned N        = 8,
  parameter int unsigned WR_N     = 2,
  parameter int unsigned RD_N     = 2,
  parameter int unsigned FLOP_OUT = 0,
  parameter int unsigned BYPASS   = 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [RD_N-1:0][$clog2(N)-1:0]    ra,
  input  logic [RD_N-1:0]                   ren,
  output logic [RD_N-1:0][W-1:0]            rdata,
  output logic [RD_N-1:0]                   rvalid,
  input  logic [WR_N-1:0][$clog2(N)-1:0]    wa,
  input  logic [WR_N-1:0]                   wen,
  input  logic [WR_N-1:0][W-1:0]            wdata,
  output logic                              init_busy
);

  localparam int unsigned AW = $clog2(N);

  typedef enum logic {S_INIT = 1'b0, S_READY = 1'b1} state_t;

  state_t              state;
  logic [AW-1:0]       cnt;
  logic [W-1:0]        mem [N];
  logic [N-1:0]        vld;
  logic [WR_N-1:0]     wr_ok;
  logic [RD_N-1:0][W-1:0] rd_data_c;
  logic [RD_N-1:0]     rd_vld_c;

  // Sweep controller: N cycles in INIT, then READY until the next reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_INIT;
      cnt       <= '0;
      init_busy <= 1'b1;
    end else begin
      case (state)
        S_INIT: begin
          if (cnt == AW'(N - 1)) begin
            state     <= S_READY;
            init_busy <= 1'b0;
            cnt       <= '0;
          end else begin
            cnt <= cnt + AW'(1);
          end
        end
        S_READY: begin
          state <= S_READY;
        end
        default: begin
          state     <= S_INIT;
          cnt       <= '0;
          init_busy <= 1'b1;
        end
      endcase
    end
  end

  // A write is live only in READY and only for an in-range address.
  always_comb begin
    wr_ok = '0;
    for (int j = 0; j < int'(WR_N); j++) begin
      wr_ok[j] = wen[j] && (state == S_READY) && (32'(wa[j]) < N);
    end
  end

  // Storage has no reset; the sweep is the only thing that clears it.
  // Later ports are applied last, so the highest-index port wins a conflict.
  always_ff @(posedge clk) begin
    if (state == S_INIT) begin
      mem[cnt] <= '0;
      vld[cnt] <= 1'b0;
    end else begin
      for (int j = 0; j < int'(WR_N); j++) begin
        if (wr_ok[j]) begin
          mem[wa[j]] <= wdata[j];
          vld[wa[j]] <= 1'b1;
        end
      end
    end
  end

  // Read lookup with optional forwarding of this cycle's winning write.
  always_comb begin
    rd_data_c = '0;
    rd_vld_c  = '0;
    for (int i = 0; i < int'(RD_N); i++) begin
      if ((state == S_READY) && (32'(ra[i]) < N)) begin
        rd_data_c[i] = mem[ra[i]];
        rd_vld_c[i]  = vld[ra[i]];
        if (BYPASS != 0) begin
          for (int j = 0; j < int'(WR_N); j++) begin
            if (wr_ok[j] && (wa[j] == ra[i])) begin
              rd_data_c[i] = wdata[j];
              rd_vld_c[i]  = 1'b1;
            end
          end
        end
      end
    end
  end

  generate
    if (FLOP_OUT != 0) begin : g_flop
      // Registered outputs capture on ren and hold otherwise.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          rdata  <= '0;
          rvalid <= '0;
        end else begin
          for (int i = 0; i < int'(RD_N); i++) begin
            if (ren[i]) begin
              rdata[i]  <= rd_data_c[i];
              rvalid[i] <= rd_vld_c[i];
            end
          end
        end
      end
    end else begin : g_comb
      logic unused_ren;
      assign unused_ren = ^ren;
      assign rdata  = rd_data_c;
      assign rvalid = rd_vld_c;
    end
  endgenerate

endmodule

// File: tb/tb_rf_mp.sv
// tb_rf_mp: directed bench for rf_mp. Four instances share the stimulus:
//   u0 N=8 combinational with bypass, u1 N=8 flopped with bypass,
//   u2 N=8 flopped without bypass, u3 N=6 combinational with bypass.
module tb_rf_mp;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [1:0][2:0]  ra, wa;
  logic [1:0]       ren, wen;
  logic [1:0][31:0] wdata;

  logic [1:0][31:0] rd0, rd1, rd2, rd3;
  logic [1:0]       rv0, rv1, rv2, rv3;
  logic             busy0, busy1, busy2, busy3;

  rf_mp #(.W(32), .N(8), .WR_N(2), .RD_N(2), .FLOP_OUT(0), .BYPASS(1)) u0 (
    .clk(clk), .rst(rst), .ra(ra), .ren(ren), .rdata(rd0), .rvalid(rv0),
    .wa(wa), .wen(wen), .wdata(wdata), .init_busy(busy0));
  rf_mp #(.W(32), .N(8), .WR_N(2), .RD_N(2), .FLOP_OUT(1), .BYPASS(1)) u1 (
    .clk(clk), .rst(rst), .ra(ra), .ren(ren), .rdata(rd1), .rvalid(rv1),
    .wa(wa), .wen(wen), .wdata(wdata), .init_busy(busy1));
  rf_mp #(.W(32), .N(8), .WR_N(2), .RD_N(2), .FLOP_OUT(1), .BYPASS(0)) u2 (
    .clk(clk), .rst(rst), .ra(ra), .ren(ren), .rdata(rd2), .rvalid(rv2),
    .wa(wa), .wen(wen), .wdata(wdata), .init_busy(busy2));
  rf_mp #(.W(32), .N(6), .WR_N(2), .RD_N(2), .FLOP_OUT(0), .BYPASS(1)) u3 (
    .clk(clk), .rst(rst), .ra(ra), .ren(ren), .rdata(rd3), .rvalid(rv3),
    .wa(wa), .wen(wen), .wdata(wdata), .init_busy(busy3));

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle();
    wen = 2'b00;
    ren = 2'b00;
  endtask

  // Counts negedge samples with init_busy high; optionally drives dropped
  // writes to addr 1 during the first five sweep cycles.
  task automatic count_busy(input bit poke, output int c8, output int c6);
    c8 = 0;
    c6 = 0;
    if (poke) begin
      wen = 2'b11; wa[0] = 3'd1; wa[1] = 3'd1;
      wdata[0] = 32'h1111_0001; wdata[1] = 32'h2222_0001;
      ra[0] = 3'd1; ra[1] = 3'd1;
    end
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (busy0) begin
        chk("init_rdata", rd0[0], 32'h0);
        chk("init_rvalid", 32'(rv0[0]), 32'h0);
      end
      if (busy0) c8++;
      if (busy3) c6++;
      if (k == 4) wen = 2'b00;
      if (!busy0 && !busy3) break;
    end
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic [1:0]  wen;
    logic [2:0]  wa0;
    logic [2:0]  wa1;
    logic [31:0] wd0;
    logic [31:0] wd1;
    logic [2:0]  ra0;
    logic [2:0]  ra1;
    logic [31:0] ed0;
    logic        ev0;
    logic [31:0] ed1;
    logic        ev1;
  } vec_t;

  vec_t        tbl [8];
  logic [31:0] e6d [6];
  logic        e6v [6];
  int          c8, c6;

  initial begin
    // Expected values for u0 (N=8, comb, bypass), checked in the same cycle.
    tbl[0] = '{2'b01, 3'd3, 3'd0, 32'hDEADBEEF, 32'h0, 3'd3, 3'd4, 32'hDEADBEEF, 1'b1, 32'h0, 1'b0};
    tbl[1] = '{2'b00, 3'd0, 3'd0, 32'h0, 32'h0, 3'd3, 3'd3, 32'hDEADBEEF, 1'b1, 32'hDEADBEEF, 1'b1};
    tbl[2] = '{2'b11, 3'd5, 3'd5, 32'h11, 32'h22, 3'd5, 3'd3, 32'h22, 1'b1, 32'hDEADBEEF, 1'b1};
    tbl[3] = '{2'b00, 3'd0, 3'd0, 32'h0, 32'h0, 3'd5, 3'd1, 32'h22, 1'b1, 32'h0, 1'b0};
    tbl[4] = '{2'b01, 3'd7, 3'd0, 32'h77, 32'h0, 3'd7, 3'd6, 32'h77, 1'b1, 32'h0, 1'b0};
    tbl[5] = '{2'b10, 3'd0, 3'd0, 32'h0, 32'hAAAA, 3'd7, 3'd0, 32'h77, 1'b1, 32'hAAAA, 1'b1};
    tbl[6] = '{2'b11, 3'd2, 3'd6, 32'h1, 32'h66, 3'd2, 3'd6, 32'h1, 1'b1, 32'h66, 1'b1};
    tbl[7] = '{2'b00, 3'd0, 3'd0, 32'h0, 32'h0, 3'd0, 3'd2, 32'hAAAA, 1'b1, 32'h1, 1'b1};
    // u3 (N=6) contents after all in-range writes below.
    e6d[0] = 32'hAAAA;     e6v[0] = 1'b1;
    e6d[1] = 32'h0;        e6v[1] = 1'b0;
    e6d[2] = 32'hA5;       e6v[2] = 1'b1;
    e6d[3] = 32'hDEADBEEF; e6v[3] = 1'b1;
    e6d[4] = 32'hB4;       e6v[4] = 1'b1;
    e6d[5] = 32'h22;       e6v[5] = 1'b1;

    // Reset state.
    rst = 1'b1; idle();
    ra = '0; wa = '0; wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy0), 32'h1);
    chk("rst_flop_rdata", rd1[1], 32'h0);
    chk("rst_flop_rvalid", 32'(rv1[1]), 32'h0);

    // Sweep length for N=8 and N=6, with dropped writes during INIT.
    rst = 1'b0;
    count_busy(1'b1, c8, c6);
    chk("sweep_len_n8", 32'(c8), 32'd8);
    chk("sweep_len_n6", 32'(c6), 32'd6);
    chk("ready_busy", 32'(busy1), 32'h0);

    // Table-driven READY traffic.
    for (int v = 0; v < 8; v++) begin
      wen = tbl[v].wen; wa[0] = tbl[v].wa0; wa[1] = tbl[v].wa1;
      wdata[0] = tbl[v].wd0; wdata[1] = tbl[v].wd1;
      ra[0] = tbl[v].ra0; ra[1] = tbl[v].ra1; ren = 2'b00;
      @(negedge clk);
      chk($sformatf("vec%0d_rdata0", v), rd0[0], tbl[v].ed0);
      chk($sformatf("vec%0d_rvalid0", v), 32'(rv0[0]), 32'(tbl[v].ev0));
      chk($sformatf("vec%0d_rdata1", v), rd0[1], tbl[v].ed1);
      chk($sformatf("vec%0d_rvalid1", v), 32'(rv0[1]), 32'(tbl[v].ev1));
      @(posedge clk); #1;
    end
    idle();

    // Flopped read with same-cycle write to a valid entry (old value 1).
    wen = 2'b01; wa[0] = 3'd2; wdata[0] = 32'hA5; ra[1] = 3'd2; ren = 2'b10;
    @(negedge clk);
    chk("flop_latency", rd1[1], 32'h0);
    chk("comb_bypass_a5", rd0[1], 32'hA5);
    @(posedge clk); #1;
    idle(); ra[1] = 3'd5;
    chk("flop_byp_rdata", rd1[1], 32'hA5);
    chk("flop_byp_rvalid", 32'(rv1[1]), 32'h1);
    chk("flop_nobyp_rdata", rd2[1], 32'h1);
    chk("flop_nobyp_rvalid", 32'(rv2[1]), 32'h1);
    @(posedge clk); #1;
    chk("flop_hold", rd1[1], 32'hA5);

    // Same, to a never-written entry.
    wen = 2'b01; wa[0] = 3'd4; wdata[0] = 32'hB4; ra[1] = 3'd4; ren = 2'b10;
    @(posedge clk); #1;
    idle();
    chk("flop_byp_new_rdata", rd1[1], 32'hB4);
    chk("flop_byp_new_rvalid", 32'(rv1[1]), 32'h1);
    chk("flop_nobyp_new_rdata", rd2[1], 32'h0);
    chk("flop_nobyp_new_rvalid", 32'(rv2[1]), 32'h0);

    // Out-of-range addresses on the N=6 instance.
    wen = 2'b01; wa[0] = 3'd7; wdata[0] = 32'hF7; ra[0] = 3'd7; ra[1] = 3'd6;
    @(negedge clk);
    chk("oor_byp_rdata", rd3[0], 32'h0);
    chk("oor_byp_rvalid", 32'(rv3[0]), 32'h0);
    chk("oor6_rdata", rd3[1], 32'h0);
    chk("oor6_rvalid", 32'(rv3[1]), 32'h0);
    chk("n8_byp_addr7", rd0[0], 32'hF7);
    chk("n8_addr6", rd0[1], 32'h66);
    @(posedge clk); #1;
    idle();
    for (int a = 0; a < 6; a++) begin
      ra[0] = 3'(a);
      #1;
      chk($sformatf("n6_entry%0d_rdata", a), rd3[0], e6d[a]);
      chk($sformatf("n6_entry%0d_rvalid", a), 32'(rv3[0]), 32'(e6v[a]));
    end
    ra[0] = 3'd7;
    #1;
    chk("oor7_rdata", rd3[0], 32'h0);
    chk("oor7_rvalid", 32'(rv3[0]), 32'h0);
    @(posedge clk); #1;

    // Reset in READY, then again at INIT cycle 4: full sweep restarts.
    rst = 1'b1;
    #1;
    chk("async_rst_busy", 32'(busy0), 32'h1);
    chk("async_rst_flop", rd1[1], 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("mid_init_busy", 32'(busy0), 32'h1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    count_busy(1'b0, c8, c6);
    chk("resweep_len_n8", 32'(c8), 32'd8);
    for (int a = 0; a < 8; a++) begin
      ra[0] = 3'(a); ra[1] = 3'(7 - a);
      #1;
      chk($sformatf("post_rst%0d_rdata", a), rd0[0] | rd0[1], 32'h0);
      chk($sformatf("post_rst%0d_rvalid", a), 32'(rv0), 32'h0);
    end
    ra[0] = 3'd3; ra[1] = 3'd5; ren = 2'b11;
    @(posedge clk); #1;
    idle();
    chk("post_rst_flop_rdata", rd1[0] | rd1[1], 32'h0);
    chk("post_rst_flop_rvalid", 32'(rv1), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
